cv32e40x_ex_fu_ctrl: RTL and testbench

- Sequencing controller for the EX stage's functional units. ALU is single-cycle; MUL and DIV are multi-cycle.
- Takes the instruction held in ID/EX and issues it to the selected unit using a valid/ready handshake. Captures the multi-cycle result into a local buffer and presents ex_valid/ex_ready to the WB and ID handshakes.
- Applies controller kill/halt and frees MUL/DIV as soon as their result is buffered.

---
 rtl/cv32e40x_ex_fu_ctrl.sv | 149 ++++++++++++++
 tb/tb_cv32e40x_ex_fu_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_ex_fu_ctrl.sv
// EX-stage functional-unit sequencer: single-cycle ALU bypass, valid/ready issue to
// the multi-cycle MUL/DIV units, result buffering, and kill/halt handling.
module cv32e40x_ex_fu_ctrl #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid_i,
    input  logic [2:0]       fu_sel_i,
    input  logic [31:0]      alu_result_i,
    input  logic             kill_i,
    input  logic             halt_i,
    output logic             mul_valid_o,
    input  logic             mul_ready_i,
    input  logic             mul_valid_i,
    output logic             mul_ready_o,
    input  logic [31:0]      mul_result_i,
    output logic             div_valid_o,
    input  logic             div_ready_i,
    input  logic             div_valid_i,
    output logic             div_ready_o,
    input  logic [31:0]      div_result_i,
    output logic             abort_o,
    input  logic             wb_ready_i,
    output logic             ex_valid_o,
    output logic             ex_ready_o,
    output logic [31:0]      rf_wdata_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_RES = 2'd1;
    localparam logic [1:0] WAIT_WB  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             div_sel_q, div_sel_d;
    logic [31:0]      buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_en_q;

    logic        en, go, unit_op, op_div, u_valid, u_ready;
    logic [31:0] u_result;

    // Outputs stay quiet during reset and for the first cycle after it.
    assign en       = rst_n & out_en_q;
    assign go       = instr_valid_i & ~kill_i & ~halt_i;
    assign unit_op  = fu_sel_i[2] | fu_sel_i[1];
    assign op_div   = fu_sel_i[2];
    assign u_valid  = div_sel_q ? div_valid_i  : mul_valid_i;
    assign u_result = div_sel_q ? div_result_i : mul_result_i;

    always_comb begin
        state_d     = state_q;
        div_sel_d   = div_sel_q;
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        mul_valid_o = 1'b0;
        div_valid_o = 1'b0;
        u_ready     = 1'b0;
        abort_o     = 1'b0;
        ex_valid_o  = 1'b0;
        ex_ready_o  = 1'b0;
        rf_wdata_o  = '0;

        if (en) begin
            case (state_q)
                WAIT_RES: rf_wdata_o = u_result;
                WAIT_WB:  rf_wdata_o = buf_q;
                default:  rf_wdata_o = alu_result_i;
            endcase

            if (kill_i) begin
                // A pending request in IDLE may have been sampled by the unit, so abort it too.
                ex_ready_o = 1'b1;
                abort_o    = (state_q == WAIT_RES) |
                             ((state_q == IDLE) & instr_valid_i & unit_op);
                state_d    = IDLE;
                cnt_d      = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (go) begin
                            if (unit_op) begin
                                mul_valid_o = ~op_div;
                                div_valid_o = op_div;
                                if (op_div ? div_ready_i : mul_ready_i) begin
                                    state_d   = WAIT_RES;
                                    div_sel_d = op_div;
                                    cnt_d     = '0;
                                end
                            end else begin
                                ex_valid_o = 1'b1;
                                ex_ready_o = wb_ready_i;
                            end
                        end else begin
                            ex_ready_o = ~instr_valid_i;
                        end
                    end
                    WAIT_RES: begin
                        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                        if (u_valid) begin
                            u_ready = 1'b1;
                            if (wb_ready_i & ~halt_i) begin
                                ex_valid_o = 1'b1;
                                ex_ready_o = 1'b1;
                                state_d    = IDLE;
                            end else begin
                                buf_d      = u_result;
                                ex_valid_o = ~halt_i;
                                state_d    = WAIT_WB;
                            end
                        end
                    end
                    WAIT_WB: begin
                        ex_valid_o = ~halt_i;
                        if (~halt_i & wb_ready_i) begin
                            ex_ready_o = 1'b1;
                            state_d    = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    assign mul_ready_o = u_ready & ~div_sel_q;
    assign div_ready_o = u_ready & div_sel_q;
    assign busy_o      = en & (state_q != IDLE);
    assign stall_cnt_o = en ? cnt_q : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_sel_q <= 1'b0;
            buf_q     <= '0;
            cnt_q     <= '0;
            out_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_sel_q <= div_sel_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            out_en_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cv32e40x_ex_fu_ctrl.sv
// Scoreboard bench for cv32e40x_ex_fu_ctrl: directed scenarios plus random traffic
// checked against an operation-level reference model.
module tb_cv32e40x_ex_fu_ctrl;

    localparam int unsigned CNT_W = 6;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, instr_valid_i, kill_i, halt_i, wb_ready_i;
    logic [2:0]       fu_sel_i;
    logic [31:0]      alu_result_i, mul_result_i, div_result_i, rf_wdata_o;
    logic             mul_valid_o, mul_ready_i, mul_valid_i, mul_ready_o;
    logic             div_valid_o, div_ready_i, div_valid_i, div_ready_o;
    logic             abort_o, ex_valid_o, ex_ready_o, busy_o;
    logic [CNT_W-1:0] stall_cnt_o;

    cv32e40x_ex_fu_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid_i), .fu_sel_i(fu_sel_i),
        .alu_result_i(alu_result_i), .kill_i(kill_i), .halt_i(halt_i),
        .mul_valid_o(mul_valid_o), .mul_ready_i(mul_ready_i), .mul_valid_i(mul_valid_i),
        .mul_ready_o(mul_ready_o), .mul_result_i(mul_result_i),
        .div_valid_o(div_valid_o), .div_ready_i(div_ready_i), .div_valid_i(div_valid_i),
        .div_ready_o(div_ready_o), .div_result_i(div_result_i),
        .abort_o(abort_o), .wb_ready_i(wb_ready_i), .ex_valid_o(ex_valid_o),
        .ex_ready_o(ex_ready_o), .rf_wdata_o(rf_wdata_o), .busy_o(busy_o),
        .stall_cnt_o(stall_cnt_o)
    );

    typedef struct packed {
        logic        rst_n, iv;
        logic [2:0]  sel;
        logic [31:0] alu;
        logic        kill, halt, mr, mv;
        logic [31:0] mres;
        logic        dr, dv;
        logic [31:0] dres;
        logic        wbr;
    } in_t;

    typedef struct packed {
        logic             mul_v, mul_r, div_v, div_r, abort, exv, exr, busy;
        logic [31:0]      wdata;
        logic             cmp_wdata;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle    = 0;

    // Reference: one outstanding unit op, optionally with its result parked in a buffer.
    bit          alive    = 0;
    bit          inflight = 0;
    bit          is_div   = 0;
    bit          buffered = 0;
    logic [31:0] bufv     = '0;
    int unsigned waited   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, act, req);
        end
    endtask

    task automatic drive(input in_t x);
        exp_t        e;
        bit          unit_op, op_div, uv;
        logic [31:0] res;
        rst_n = x.rst_n; instr_valid_i = x.iv; fu_sel_i = x.sel; alu_result_i = x.alu;
        kill_i = x.kill; halt_i = x.halt; mul_ready_i = x.mr; mul_valid_i = x.mv;
        mul_result_i = x.mres; div_ready_i = x.dr; div_valid_i = x.dv;
        div_result_i = x.dres; wb_ready_i = x.wbr;

        e = '0;
        e.cmp_wdata = 1'b1;
        if (x.rst_n && alive) begin
            unit_op     = x.sel[2] | x.sel[1];
            op_div      = x.sel[2];
            e.cnt       = waited[CNT_W-1:0];
            e.busy      = inflight;
            e.cmp_wdata = 1'b0;
            if (x.kill) begin
                e.exr   = 1'b1;
                e.abort = (inflight && !buffered) || (!inflight && x.iv && unit_op);
                if (buffered) begin e.wdata = bufv; e.cmp_wdata = 1'b1; end
                inflight = 0; buffered = 0; waited = 0;
            end else if (!inflight) begin
                if (x.iv && !x.halt) begin
                    if (!unit_op) begin
                        e.exv = 1'b1; e.wdata = x.alu; e.cmp_wdata = 1'b1; e.exr = x.wbr;
                    end else begin
                        e.mul_v = !op_div; e.div_v = op_div;
                        if (op_div ? x.dr : x.mr) begin
                            inflight = 1; is_div = op_div; waited = 0;
                        end
                    end
                end else begin
                    e.exr = !x.iv;
                end
            end else if (!buffered) begin
                uv  = is_div ? x.dv : x.mv;
                res = is_div ? x.dres : x.mres;
                if (waited < CNT_MAX) waited++;
                if (uv) begin
                    e.mul_r = !is_div; e.div_r = is_div;
                    e.wdata = res; e.cmp_wdata = 1'b1;
                    if (x.wbr && !x.halt) begin
                        e.exv = 1'b1; e.exr = 1'b1; inflight = 0;
                    end else begin
                        e.exv = !x.halt; buffered = 1; bufv = res;
                    end
                end
            end else begin
                e.wdata = bufv; e.cmp_wdata = 1'b1; e.exv = !x.halt;
                if (!x.halt && x.wbr) begin
                    e.exr = 1'b1; inflight = 0; buffered = 0;
                end
            end
        end
        if (!x.rst_n) begin
            alive = 0; inflight = 0; is_div = 0; buffered = 0; bufv = '0; waited = 0;
        end else begin
            alive = 1;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("mul_valid_o", {31'b0, mul_valid_o}, {31'b0, e.mul_v});
            chk("mul_ready_o", {31'b0, mul_ready_o}, {31'b0, e.mul_r});
            chk("div_valid_o", {31'b0, div_valid_o}, {31'b0, e.div_v});
            chk("div_ready_o", {31'b0, div_ready_o}, {31'b0, e.div_r});
            chk("abort_o", {31'b0, abort_o}, {31'b0, e.abort});
            chk("ex_valid_o", {31'b0, ex_valid_o}, {31'b0, e.exv});
            chk("ex_ready_o", {31'b0, ex_ready_o}, {31'b0, e.exr});
            chk("busy_o", {31'b0, busy_o}, {31'b0, e.busy});
            chk("stall_cnt_o", {{(32-CNT_W){1'b0}}, stall_cnt_o}, {{(32-CNT_W){1'b0}}, e.cnt});
            if (e.cmp_wdata) chk("rf_wdata_o", rf_wdata_o, e.wdata);
            chk("one_hot_issue", {31'b0, mul_valid_o & div_valid_o}, 32'd0);
            cycle++;
        end
    end

    function automatic in_t idle_in();
        in_t x;
        x = '0;
        x.rst_n = 1'b1;
        x.wbr   = 1'b1;
        return x;
    endfunction

    initial begin
        in_t x;
        rst_n = 1'b0; instr_valid_i = 1'b0; fu_sel_i = '0; alu_result_i = '0;
        kill_i = 1'b0; halt_i = 1'b0; mul_ready_i = 1'b0; mul_valid_i = 1'b0;
        mul_result_i = '0; div_ready_i = 1'b0; div_valid_i = 1'b0; div_result_i = '0;
        wb_ready_i = 1'b0;
        @(posedge clk); #1;

        x = idle_in(); x.rst_n = 1'b0;
        repeat (2) drive(x);
        drive(idle_in());
        drive(idle_in());

        // ALU bypass, then NOP select with WB stalled
        x = idle_in(); x.iv = 1; x.sel = 3'b001; x.alu = 32'h1234; drive(x);
        x.sel = 3'b000; x.alu = 32'h55AA; x.wbr = 0; drive(x);

        // MUL, 3 cycles in WAIT_RES, direct write-back
        x = idle_in(); x.iv = 1; x.sel = 3'b010; x.mr = 1; drive(x);
        x = idle_in(); x.mres = 32'hCAFE; repeat (2) drive(x);
        x.mv = 1; drive(x);
        drive(idle_in());

        // DIV completes while WB is stalled
        x = idle_in(); x.iv = 1; x.sel = 3'b100; x.dr = 1; drive(x);
        x = idle_in(); x.dres = 32'h7; drive(x);
        x.dv = 1; x.wbr = 0; drive(x);
        x.dv = 0; x.dres = 32'h99; drive(x);
        x.wbr = 1; drive(x);
        drive(idle_in());

        // Kill in WAIT_RES racing the DIV result
        x = idle_in(); x.iv = 1; x.sel = 3'b100; x.dr = 1; drive(x);
        x = idle_in(); drive(x);
        x.dv = 1; x.dres = 32'hDEAD; x.kill = 1; drive(x);
        drive(idle_in());

        // Halt across MUL completion; issue blocked while halted
        x = idle_in(); x.iv = 1; x.sel = 3'b010; x.mr = 1; drive(x);
        x = idle_in(); x.halt = 1; drive(x);
        x.mv = 1; x.mres = 32'hBEEF; drive(x);
        x.mv = 0; x.iv = 1; x.sel = 3'b010; x.mr = 1; repeat (2) drive(x);
        drive(idle_in());
        drive(idle_in());

        // Long DIV stall saturates the counter, then reset mid-operation
        x = idle_in(); x.iv = 1; x.sel = 3'b100; x.dr = 1; drive(x);
        x = idle_in(); repeat (70) drive(x);
        x.rst_n = 0; drive(x);
        drive(idle_in());
        drive(idle_in());

        for (int i = 0; i < 3000; i++) begin
            x.rst_n = ($urandom_range(0, 199) != 0);
            x.iv    = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: x.sel = 3'b000;
                1: x.sel = 3'b001;
                2: x.sel = 3'b010;
                default: x.sel = 3'b100;
            endcase
            x.alu  = $urandom;
            x.kill = ($urandom_range(0, 15) == 0);
            x.halt = ($urandom_range(0, 5) == 0);
            x.mr   = $urandom_range(0, 1);
            x.mv   = ($urandom_range(0, 3) == 0);
            x.mres = $urandom;
            x.dr   = $urandom_range(0, 1);
            x.dv   = ($urandom_range(0, 3) == 0);
            x.dres = $urandom;
            x.wbr  = ($urandom_range(0, 2) != 0);
            drive(x);
        end

        drive(idle_in());
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
